// File: rtl/pipe_pkg.sv
// Shared types and constants for the MIPS pipeline hazard/stall logic.
package pipe_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] ZERO_REG = 5'd0;
    localparam int LOAD_USE_BUBBLES = 1;
    localparam int BR_LOAD_BUBBLES  = 2;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        STALL    = 2'd1,
        MEM_WAIT = 2'd2
    } stall_state_t;

    // $zero never carries a dependency, so it can never match a producer.
    function automatic logic regMatch(input logic [REG_W-1:0] producer,
                                      input logic [REG_W-1:0] consumer);
        return (producer != ZERO_REG) && (producer == consumer);
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational bubble-count computation for hazards that forwarding cannot cover.
module hazard_detect
    import pipe_pkg::*;
#(
    parameter int MAX_BUBBLES = 2,
    localparam int BW = $clog2(MAX_BUBBLES + 1)
) (
    input  logic [REG_W-1:0] RegisterRs,
    input  logic [REG_W-1:0] RegisterRt,
    input  logic             ID_use_rs,
    input  logic             ID_use_rt,
    input  logic             ID_branch,
    input  logic             ID_EX_MemRead,
    input  logic             ID_EX_RegWrite,
    input  logic [REG_W-1:0] ID_EX_RegisterRd,
    input  logic             EX_MEM_MemRead,
    input  logic             EX_MEM_RegWrite,
    input  logic [REG_W-1:0] EX_MEM_RegisterRd,
    output logic [BW-1:0]    bubbles
);

    logic exHit_s;
    logic memRsHit_s;
    logic memRtHit_s;
    logic loadUse_s;
    logic brLoad_s;
    logic brAlu_s;
    logic brMem_s;

    // Operand matches against the EX and MEM producers, then the hazard classes.
    always_comb begin
        exHit_s    = (ID_use_rs && regMatch(ID_EX_RegisterRd, RegisterRs)) ||
                     (ID_use_rt && regMatch(ID_EX_RegisterRd, RegisterRt));
        memRsHit_s = ID_use_rs && regMatch(EX_MEM_RegisterRd, RegisterRs);
        memRtHit_s = ID_use_rt && regMatch(EX_MEM_RegisterRd, RegisterRt);

        loadUse_s = ID_EX_MemRead && exHit_s;
        brLoad_s  = ID_branch && ID_EX_MemRead && exHit_s;
        brAlu_s   = ID_branch && !ID_EX_MemRead && ID_EX_RegWrite && exHit_s;
        // A load in MEM has no ALU bypass for rs, and rt has no MEM bypass at all.
        brMem_s   = ID_branch && ((EX_MEM_MemRead && memRsHit_s) ||
                                  (EX_MEM_RegWrite && memRtHit_s));
    end

    // The longest requirement wins.
    always_comb begin
        if (brLoad_s) begin
            bubbles = BW'(BR_LOAD_BUBBLES);
        end else if (loadUse_s || brAlu_s || brMem_s) begin
            bubbles = BW'(LOAD_USE_BUBBLES);
        end else begin
            bubbles = {BW{1'b0}};
        end
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall/flush controller for the 5-stage MIPS pipeline.
// Optional performance counters are enabled with `define HAZARD_PERF_CNT_EN.
module hazard_stall_unit
    import pipe_pkg::*;
#(
    parameter int MAX_BUBBLES = 2
`ifdef HAZARD_PERF_CNT_EN
    , parameter int CNT_W = 32
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] RegisterRs,
    input  logic [REG_W-1:0] RegisterRt,
    input  logic             ID_use_rs,
    input  logic             ID_use_rt,
    input  logic             ID_branch,
    input  logic             ID_taken,
    input  logic             ID_EX_MemRead,
    input  logic             ID_EX_RegWrite,
    input  logic [REG_W-1:0] ID_EX_RegisterRd,
    input  logic             EX_MEM_MemRead,
    input  logic             EX_MEM_RegWrite,
    input  logic [REG_W-1:0] EX_MEM_RegisterRd,
    input  logic             mem_busy,
`ifdef HAZARD_PERF_CNT_EN
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] wait_cycles,
    output logic [CNT_W-1:0] flush_count,
`endif
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic             EX_MEM_Write,
    output logic             MEM_WB_Write
);

    localparam int BW = $clog2(MAX_BUBBLES + 1);

    stall_state_t  state_r;
    stall_state_t  stateNext_s;
    logic [BW-1:0] cnt_r;
    logic [BW-1:0] cntNext_s;
    logic          retStall_r;
    logic          retStallNext_s;
    logic [BW-1:0] bubbles_s;

    hazard_detect #(.MAX_BUBBLES(MAX_BUBBLES)) u_detect (
        .RegisterRs       (RegisterRs),
        .RegisterRt       (RegisterRt),
        .ID_use_rs        (ID_use_rs),
        .ID_use_rt        (ID_use_rt),
        .ID_branch        (ID_branch),
        .ID_EX_MemRead    (ID_EX_MemRead),
        .ID_EX_RegWrite   (ID_EX_RegWrite),
        .ID_EX_RegisterRd (ID_EX_RegisterRd),
        .EX_MEM_MemRead   (EX_MEM_MemRead),
        .EX_MEM_RegWrite  (EX_MEM_RegWrite),
        .EX_MEM_RegisterRd(EX_MEM_RegisterRd),
        .bubbles          (bubbles_s)
    );

    // State, remaining-bubble count and MEM_WAIT return target.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= RUN;
            cnt_r      <= {BW{1'b0}};
            retStall_r <= 1'b0;
        end else begin
            state_r    <= stateNext_s;
            cnt_r      <= cntNext_s;
            retStall_r <= retStallNext_s;
        end
    end

    // Next-state and pipeline control; a held ID instruction is only re-decoded in RUN.
    always_comb begin
        stateNext_s    = state_r;
        cntNext_s      = cnt_r;
        retStallNext_s = retStall_r;
        PC_Write       = 1'b1;
        IF_ID_Write    = 1'b1;
        IF_ID_Flush    = 1'b0;
        ID_EX_Flush    = 1'b0;
        EX_MEM_Write   = 1'b1;
        MEM_WB_Write   = 1'b1;

        if (reset) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            IF_ID_Flush  = 1'b1;
            ID_EX_Flush  = 1'b1;
            EX_MEM_Write = 1'b0;
            MEM_WB_Write = 1'b0;
        end else begin
            case (state_r)
                RUN: begin
                    if (mem_busy) begin
                        PC_Write       = 1'b0;
                        IF_ID_Write    = 1'b0;
                        EX_MEM_Write   = 1'b0;
                        MEM_WB_Write   = 1'b0;
                        retStallNext_s = 1'b0;
                        stateNext_s    = MEM_WAIT;
                    end else if (bubbles_s != {BW{1'b0}}) begin
                        PC_Write    = 1'b0;
                        IF_ID_Write = 1'b0;
                        ID_EX_Flush = 1'b1;
                        cntNext_s   = bubbles_s - BW'(1);
                        stateNext_s = (bubbles_s > BW'(1)) ? STALL : RUN;
                    end else begin
                        IF_ID_Flush = ID_branch & ID_taken;
                    end
                end
                STALL: begin
                    if (mem_busy) begin
                        PC_Write       = 1'b0;
                        IF_ID_Write    = 1'b0;
                        EX_MEM_Write   = 1'b0;
                        MEM_WB_Write   = 1'b0;
                        retStallNext_s = 1'b1;
                        stateNext_s    = MEM_WAIT;
                    end else begin
                        PC_Write    = 1'b0;
                        IF_ID_Write = 1'b0;
                        ID_EX_Flush = 1'b1;
                        cntNext_s   = (cnt_r != {BW{1'b0}}) ? (cnt_r - BW'(1)) : {BW{1'b0}};
                        stateNext_s = (cnt_r <= BW'(1)) ? RUN : STALL;
                    end
                end
                MEM_WAIT: begin
                    PC_Write     = 1'b0;
                    IF_ID_Write  = 1'b0;
                    EX_MEM_Write = 1'b0;
                    MEM_WB_Write = 1'b0;
                    if (!mem_busy) begin
                        stateNext_s = retStall_r ? STALL : RUN;
                    end else begin
                        stateNext_s = MEM_WAIT;
                    end
                end
                default: begin
                    PC_Write       = 1'b0;
                    IF_ID_Write    = 1'b0;
                    EX_MEM_Write   = 1'b0;
                    MEM_WB_Write   = 1'b0;
                    cntNext_s      = {BW{1'b0}};
                    retStallNext_s = 1'b0;
                    stateNext_s    = RUN;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic stallCycle_s;
    logic frozenCycle_s;

    // A bubble cycle keeps the back end moving; a frozen cycle stops it.
    always_comb begin
        stallCycle_s  = !reset && ID_EX_Flush && EX_MEM_Write;
        frozenCycle_s = !reset && !EX_MEM_Write;
    end

    // Saturating performance counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= {CNT_W{1'b0}};
            wait_cycles  <= {CNT_W{1'b0}};
            flush_count  <= {CNT_W{1'b0}};
        end else begin
            if (stallCycle_s && (stall_cycles != {CNT_W{1'b1}})) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end else begin
                stall_cycles <= stall_cycles;
            end
            if (frozenCycle_s && (wait_cycles != {CNT_W{1'b1}})) begin
                wait_cycles <= wait_cycles + CNT_W'(1);
            end else begin
                wait_cycles <= wait_cycles;
            end
            if (IF_ID_Flush && (flush_count != {CNT_W{1'b1}})) begin
                flush_count <= flush_count + CNT_W'(1);
            end else begin
                flush_count <= flush_count;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed table plus randomized comparison against a cycle-level reference model.
module tb_hazard_stall_unit;

    typedef struct packed {
        logic       rst;
        logic       busy;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       useRs;
        logic       useRt;
        logic       branch;
        logic       taken;
        logic       exMemRead;
        logic       exRegWrite;
        logic [4:0] exRd;
        logic       memMemRead;
        logic       memRegWrite;
        logic [4:0] memRd;
    } stim_t;

    typedef struct packed {
        stim_t      in;
        logic [5:0] exp;
    } vec_t;

    // {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Write, MEM_WB_Write}
    localparam logic [5:0] E_NORM  = 6'b110011;
    localparam logic [5:0] E_TAKEN = 6'b111011;
    localparam logic [5:0] E_STALL = 6'b000111;
    localparam logic [5:0] E_FRZ   = 6'b000000;
    localparam logic [5:0] E_RST   = 6'b001100;

    logic clk = 1'b0;
    logic reset;
    logic [4:0] RegisterRs, RegisterRt, ID_EX_RegisterRd, EX_MEM_RegisterRd;
    logic ID_use_rs, ID_use_rt, ID_branch, ID_taken;
    logic ID_EX_MemRead, ID_EX_RegWrite, EX_MEM_MemRead, EX_MEM_RegWrite, mem_busy;
    logic PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Write, MEM_WB_Write;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles, wait_cycles, flush_count;
`endif

    int checks = 0;
    int errors = 0;
    int mRemain = 0;
    bit mWait = 1'b0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    hazard_stall_unit dut (
        .clk              (clk),
        .reset            (reset),
        .RegisterRs       (RegisterRs),
        .RegisterRt       (RegisterRt),
        .ID_use_rs        (ID_use_rs),
        .ID_use_rt        (ID_use_rt),
        .ID_branch        (ID_branch),
        .ID_taken         (ID_taken),
        .ID_EX_MemRead    (ID_EX_MemRead),
        .ID_EX_RegWrite   (ID_EX_RegWrite),
        .ID_EX_RegisterRd (ID_EX_RegisterRd),
        .EX_MEM_MemRead   (EX_MEM_MemRead),
        .EX_MEM_RegWrite  (EX_MEM_RegWrite),
        .EX_MEM_RegisterRd(EX_MEM_RegisterRd),
        .mem_busy         (mem_busy),
`ifdef HAZARD_PERF_CNT_EN
        .stall_cycles     (stall_cycles),
        .wait_cycles      (wait_cycles),
        .flush_count      (flush_count),
`endif
        .PC_Write         (PC_Write),
        .IF_ID_Write      (IF_ID_Write),
        .IF_ID_Flush      (IF_ID_Flush),
        .ID_EX_Flush      (ID_EX_Flush),
        .EX_MEM_Write     (EX_MEM_Write),
        .MEM_WB_Write     (MEM_WB_Write)
    );

    task automatic drive(input stim_t s);
        reset             = s.rst;
        mem_busy          = s.busy;
        RegisterRs        = s.rs;
        RegisterRt        = s.rt;
        ID_use_rs         = s.useRs;
        ID_use_rt         = s.useRt;
        ID_branch         = s.branch;
        ID_taken          = s.taken;
        ID_EX_MemRead     = s.exMemRead;
        ID_EX_RegWrite    = s.exRegWrite;
        ID_EX_RegisterRd  = s.exRd;
        EX_MEM_MemRead    = s.memMemRead;
        EX_MEM_RegWrite   = s.memRegWrite;
        EX_MEM_RegisterRd = s.memRd;
    endtask

    task automatic check(input string name, input logic [5:0] got, input logic [5:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    function automatic int maxInt(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic bit hit(input logic [4:0] prod, input logic [4:0] src, input logic use_);
        return use_ && (prod != 5'd0) && (prod == src);
    endfunction

    // Bubble requirement as the maximum over the hazard rules.
    function automatic int refBubbles(input stim_t s);
        int b = 0;
        bit exHit = hit(s.exRd, s.rs, s.useRs) || hit(s.exRd, s.rt, s.useRt);
        if (s.exMemRead && exHit) b = maxInt(b, 1);
        if (s.branch) begin
            if (s.exMemRead && exHit) b = maxInt(b, 2);
            else if (s.exRegWrite && exHit) b = maxInt(b, 1);
            if (s.memMemRead && hit(s.memRd, s.rs, s.useRs)) b = maxInt(b, 1);
            if (s.memRegWrite && hit(s.memRd, s.rt, s.useRt)) b = maxInt(b, 1);
        end
        return b;
    endfunction

    // Reference: pending bubble count plus a "waiting on memory" flag.
    task automatic modelStep(input stim_t s, output logic [5:0] e);
        int b;
        if (s.rst) begin
            e = E_RST; mRemain = 0; mWait = 1'b0;
        end else if (mWait) begin
            e = E_FRZ;
            if (!s.busy) mWait = 1'b0;
        end else if (s.busy) begin
            e = E_FRZ; mWait = 1'b1;
        end else if (mRemain > 0) begin
            e = E_STALL; mRemain--;
        end else begin
            b = refBubbles(s);
            if (b > 0) begin
                e = E_STALL; mRemain = b - 1;
            end else begin
                e = (s.branch && s.taken) ? E_TAKEN : E_NORM;
            end
        end
    endtask

    function automatic stim_t brLoad();
        stim_t s = '0;
        s.branch = 1'b1; s.rs = 5'd8; s.useRs = 1'b1; s.rt = 5'd0; s.useRt = 1'b1;
        s.exMemRead = 1'b1; s.exRegWrite = 1'b1; s.exRd = 5'd8;
        return s;
    endfunction

    function automatic stim_t brAlu(input logic taken);
        stim_t s = '0;
        s.branch = 1'b1; s.taken = taken; s.rt = 5'd3; s.useRt = 1'b1;
        s.exRegWrite = 1'b1; s.exRd = 5'd3;
        return s;
    endfunction

    task automatic add(input stim_t s, input logic [5:0] e);
        tbl.push_back('{in: s, exp: e});
    endtask

    logic [5:0] obs;
    assign obs = {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Write, MEM_WB_Write};

    initial begin
        stim_t s;
        stim_t nop;
        logic [5:0] mexp;

        nop = '0;
        s = nop; s.rst = 1'b1;                                      add(s, E_RST);
        add(nop, E_NORM);
        s = nop; s.exMemRead = 1'b1; s.exRegWrite = 1'b1; s.exRd = 5'd8;
        s.rs = 5'd8; s.useRs = 1'b1;                                add(s, E_STALL);
        s = nop; s.rs = 5'd8; s.useRs = 1'b1;                       add(s, E_NORM);
        add(brLoad(), E_STALL);
        s = brLoad(); s.taken = 1'b1;                               add(s, E_STALL);
        s = nop; s.branch = 1'b1; s.taken = 1'b1; s.rs = 5'd8; s.useRs = 1'b1;
                                                                    add(s, E_TAKEN);
        add(nop, E_NORM);
        s = nop; s.memRegWrite = 1'b1; s.memRd = 5'd5; s.branch = 1'b1;
        s.rs = 5'd1; s.useRs = 1'b1; s.rt = 5'd5; s.useRt = 1'b1;   add(s, E_STALL);
        add(nop, E_NORM);
        s = nop; s.memRegWrite = 1'b1; s.memRd = 5'd5; s.branch = 1'b1;
        s.rs = 5'd5; s.useRs = 1'b1; s.rt = 5'd1; s.useRt = 1'b1;   add(s, E_NORM);
        s = nop; s.exMemRead = 1'b1; s.exRegWrite = 1'b1; s.exRd = 5'd0;
        s.memMemRead = 1'b1; s.memRegWrite = 1'b1; s.memRd = 5'd0;
        s.branch = 1'b1; s.useRs = 1'b1; s.useRt = 1'b1;            add(s, E_NORM);
        add(brAlu(1'b0), E_STALL);
        s = nop; s.exMemRead = 1'b1; s.exRd = 5'd7; s.rs = 5'd7;    add(s, E_NORM);
        add(brLoad(), E_STALL);
        s = nop; s.busy = 1'b1;
        add(s, E_FRZ); add(s, E_FRZ); add(s, E_FRZ);
        add(nop, E_FRZ);
        add(nop, E_STALL);
        add(nop, E_NORM);
        add(s, E_FRZ);
        add(nop, E_FRZ);
        add(nop, E_NORM);
        add(brLoad(), E_STALL);
        s = nop; s.rst = 1'b1;                                      add(s, E_RST);
        add(nop, E_NORM);
        add(brAlu(1'b1), E_STALL);
        s = nop; s.branch = 1'b1; s.taken = 1'b1;                   add(s, E_TAKEN);

        foreach (tbl[i]) begin
            drive(tbl[i].in);
            @(negedge clk);
            modelStep(tbl[i].in, mexp);
            check($sformatf("vec%0d", i), obs, tbl[i].exp);
`ifdef HAZARD_PERF_CNT_EN
            if (i == 26) begin
                check("perf_after_reset", {5'd0, (stall_cycles | wait_cycles | flush_count) != 32'd0}, 6'd0);
            end
`endif
            @(posedge clk);
            #1;
        end

        for (int n = 0; n < 3000; n++) begin
            s = '0;
            s.rst         = ($urandom_range(0, 99) == 0);
            s.busy        = ($urandom_range(0, 5) == 0);
            s.rs          = 5'($urandom_range(0, 3));
            s.rt          = 5'($urandom_range(0, 3));
            s.useRs       = 1'($urandom_range(0, 1));
            s.useRt       = 1'($urandom_range(0, 1));
            s.branch      = 1'($urandom_range(0, 1));
            s.taken       = 1'($urandom_range(0, 1));
            s.exMemRead   = 1'($urandom_range(0, 1));
            s.exRegWrite  = 1'($urandom_range(0, 1));
            s.exRd        = 5'($urandom_range(0, 3));
            s.memMemRead  = 1'($urandom_range(0, 1));
            s.memRegWrite = 1'($urandom_range(0, 1));
            s.memRd       = 5'($urandom_range(0, 3));
            drive(s);
            @(negedge clk);
            modelStep(s, mexp);
            check($sformatf("rand%0d", n), obs, mexp);
            @(posedge clk);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
